// File: rtl/bnn_threshold_packer.sv
// BNN sign activation: compares each popcount against a per-channel threshold and packs N_CH bits per word.
// Optional `THRESH_FLIP_EN: each threshold carries a flip bit selecting the < compare.
module bnn_threshold_packer #(
    parameter int unsigned SUM_WIDTH = 4,
    parameter int unsigned N_CH      = 8,
    localparam int unsigned CH_W     = $clog2(N_CH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_in,
    input  logic [SUM_WIDTH-1:0] partial_sum_in,
    output logic                 in_ready,
    input  logic                 thr_we,
    input  logic [CH_W-1:0]      thr_addr,
`ifdef THRESH_FLIP_EN
    input  logic [SUM_WIDTH:0]   thr_data,
`else
    input  logic [SUM_WIDTH-1:0] thr_data,
`endif
    output logic [N_CH-1:0]      word_out,
    output logic                 word_valid,
    input  logic                 word_ready,
    output logic [CH_W-1:0]      ch_idx,
    output logic                 overflow
);

`ifdef THRESH_FLIP_EN
    localparam int unsigned TW = SUM_WIDTH + 1;
`else
    localparam int unsigned TW = SUM_WIDTH;
`endif

    typedef enum logic {COLLECT, FULL} state_t;

    state_t          state;
    logic [TW-1:0]   thr [N_CH];
    logic [N_CH-1:0] pack;
    logic [N_CH-1:0] new_word;
    logic [TW-1:0]   thr_sel;
    logic            act;
    logic            out_free;
    logic            last_ch;
    logic            thr_wr_ok;

    assign thr_sel   = thr[ch_idx];
    assign out_free  = !word_valid || word_ready;
    assign last_ch   = (ch_idx == CH_W'(N_CH - 1));
    assign thr_wr_ok = ({1'b0, thr_addr} < (CH_W + 1)'(N_CH));

    always_comb begin
`ifdef THRESH_FLIP_EN
        if (thr_sel[SUM_WIDTH])
            act = (partial_sum_in < thr_sel[SUM_WIDTH-1:0]);
        else
            act = (partial_sum_in >= thr_sel[SUM_WIDTH-1:0]);
`else
        act = (partial_sum_in >= thr_sel);
`endif
        new_word         = pack;
        new_word[ch_idx] = act;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= COLLECT;
            in_ready   <= 1'b1;
            pack       <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
            ch_idx     <= '0;
            overflow   <= 1'b0;
            for (int unsigned i = 0; i < N_CH; i++) thr[i] <= '0;
        end else begin
            // Threshold write lands at the edge, so a same-cycle compare sees the old entry.
            if (thr_we && thr_wr_ok) thr[thr_addr] <= thr_data;
            if (valid_in && !in_ready) overflow <= 1'b1;
            if (word_valid && word_ready) word_valid <= 1'b0;

            case (state)
                COLLECT: begin
                    if (valid_in) begin
                        if (last_ch) begin
                            ch_idx <= '0;
                            if (out_free) begin
                                word_out   <= new_word;
                                word_valid <= 1'b1;
                                pack       <= '0;
                            end else begin
                                pack     <= new_word;
                                state    <= FULL;
                                in_ready <= 1'b0;
                            end
                        end else begin
                            pack   <= new_word;
                            ch_idx <= ch_idx + CH_W'(1);
                        end
                    end
                end
                FULL: begin
                    if (word_valid && word_ready) begin
                        word_out   <= pack;
                        word_valid <= 1'b1;
                        pack       <= '0;
                        state      <= COLLECT;
                        in_ready   <= 1'b1;
                    end
                end
                default: begin
                    state    <= COLLECT;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bnn_threshold_packer.sv
// Testbench for bnn_threshold_packer: vector table, hand sequences and a random run against a word-queue model.
// Honours `THRESH_FLIP_EN for the threshold width and flip-bit checks.
module tb_bnn_threshold_packer;

    localparam int SUM_WIDTH = 4;
    localparam int N_CH      = 8;
    localparam int CH_W      = 3;
`ifdef THRESH_FLIP_EN
    localparam int TW = SUM_WIDTH + 1;
`else
    localparam int TW = SUM_WIDTH;
`endif

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 valid_in;
    logic [SUM_WIDTH-1:0] partial_sum_in;
    logic                 in_ready;
    logic                 thr_we;
    logic [CH_W-1:0]      thr_addr;
    logic [TW-1:0]        thr_data;
    logic [N_CH-1:0]      word_out;
    logic                 word_valid;
    logic                 word_ready;
    logic [CH_W-1:0]      ch_idx;
    logic                 overflow;

    bnn_threshold_packer #(.SUM_WIDTH(SUM_WIDTH), .N_CH(N_CH)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .partial_sum_in(partial_sum_in),
        .in_ready(in_ready), .thr_we(thr_we), .thr_addr(thr_addr), .thr_data(thr_data),
        .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
        .ch_idx(ch_idx), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: thresholds, bits collected so far, queue of finished words (output reg + held word).
    int          m_thr [N_CH];
    int          m_cnt;
    logic [7:0]  m_bits;
    logic [7:0]  m_q [$];
    bit          m_ovf;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_act(input int ch, input int s);
        int t;
        t = m_thr[ch] % (1 << SUM_WIDTH);
`ifdef THRESH_FLIP_EN
        if (m_thr[ch] >= (1 << SUM_WIDTH)) return s < t;
`endif
        return s >= t;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N_CH; i++) m_thr[i] = 0;
        m_cnt  = 0;
        m_bits = '0;
        m_q.delete();
        m_ovf  = 0;
    endtask

    task automatic m_check();
        chk("in_ready", int'(in_ready), (m_q.size() < 2) ? 1 : 0);
        chk("word_valid", int'(word_valid), (m_q.size() > 0) ? 1 : 0);
        if (m_q.size() > 0) chk("word_out", int'(word_out), int'(m_q[0]));
        chk("ch_idx", int'(ch_idx), m_cnt);
        chk("overflow", int'(overflow), int'(m_ovf));
    endtask

    // One clock: drive inputs, advance the model across the edge, check #1 after it.
    task automatic cyc(input bit v, input int s, input bit wr, input bit we, input int a, input int d);
        bit rdy_pre;
        bit done;
        logic [7:0] w;
        valid_in       = v;
        partial_sum_in = SUM_WIDTH'(s);
        word_ready     = wr;
        thr_we         = we;
        thr_addr       = CH_W'(a);
        thr_data       = TW'(d);
        @(posedge clk);
        rdy_pre = (m_q.size() < 2);
        done    = 0;
        w       = '0;
        if (v && rdy_pre) begin
            m_bits[m_cnt] = m_act(m_cnt, s);
            m_cnt++;
            if (m_cnt == N_CH) begin
                done   = 1;
                w      = m_bits;
                m_cnt  = 0;
                m_bits = '0;
            end
        end
        if (v && !rdy_pre) m_ovf = 1;
        if (wr && m_q.size() > 0) void'(m_q.pop_front());
        if (done) m_q.push_back(w);
        if (we) m_thr[a] = d;
        #1;
        m_check();
    endtask

    task automatic async_reset();
        #2 reset = 1'b1;
        #1;
        chk("rst_word_out", int'(word_out), 0);
        chk("rst_word_valid", int'(word_valid), 0);
        chk("rst_ch_idx", int'(ch_idx), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        m_reset();
        #1 reset = 1'b0;
    endtask

    typedef struct {
        logic [N_CH-1:0][SUM_WIDTH-1:0] thr;
        logic [N_CH-1:0][SUM_WIDTH-1:0] sums;
        logic [N_CH-1:0]                exp;
    } vec_t;

    vec_t vecs [4];

    initial begin
        vecs[0].thr  = '0;
        vecs[0].sums = {4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
        vecs[0].exp  = 8'hFF;
        vecs[1].thr  = {4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
        vecs[1].sums = {4'd6, 4'd7, 4'd4, 4'd5, 4'd2, 4'd3, 4'd0, 4'd1};
        vecs[1].exp  = 8'h55;
        vecs[2].thr  = {8{4'd8}};
        vecs[2].sums = {4'd12, 4'd1, 4'd8, 4'd9, 4'd0, 4'd15, 4'd7, 4'd8};
        vecs[2].exp  = 8'hB5;
        vecs[3].thr  = {8{4'd15}};
        vecs[3].sums = {4'd14, 4'd14, 4'd15, 4'd15, 4'd15, 4'd14, 4'd15, 4'd14};
        vecs[3].exp  = 8'h3A;

        reset = 1'b1; valid_in = 0; partial_sum_in = '0; word_ready = 0;
        thr_we = 0; thr_addr = '0; thr_data = '0;
        m_reset();
        #12;
        chk("rst_word_out", int'(word_out), 0);
        chk("rst_word_valid", int'(word_valid), 0);
        chk("rst_ch_idx", int'(ch_idx), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        #1 reset = 1'b0;

        // Vector table: first vector runs on reset thresholds (all zero).
        for (int i = 0; i < 4; i++) begin
            if (i > 0)
                for (int k = 0; k < N_CH; k++) cyc(0, 0, 1, 1, k, int'(vecs[i].thr[k]));
            for (int k = 0; k < N_CH; k++) cyc(1, int'(vecs[i].sums[k]), 1, 0, 0, 0);
            chk("vec_word_valid", int'(word_valid), 1);
            chk("vec_word_out", int'(word_out), int'(vecs[i].exp));
            chk("vec_ch_idx", int'(ch_idx), 0);
        end

        // Stall: two words with word_ready low, then a dropped 17th input, then drain.
        for (int k = 0; k < N_CH; k++) cyc(0, 0, 1, 1, k, 8);
        for (int k = 0; k < 16; k++) begin
            cyc(1, ((k % 2) == (k / 8)) ? 8 : 0, 0, 0, 0, 0);
            if (k >= 8) chk("stall_hold", int'(word_out), 8'h55);
        end
        chk("stall_in_ready", int'(in_ready), 0);
        cyc(1, 15, 0, 0, 0, 0);
        chk("drop_overflow", int'(overflow), 1);
        chk("drop_ch_idx", int'(ch_idx), 0);
        cyc(0, 0, 1, 0, 0, 0);
        chk("drain_word2", int'(word_out), 8'hAA);
        chk("drain_in_ready", int'(in_ready), 1);
        cyc(0, 0, 1, 0, 0, 0);
        chk("drain_empty", int'(word_valid), 0);

        // Last channel arrives in the same cycle the previous word is consumed.
        for (int k = 0; k < 15; k++) cyc(1, ((k % 2) == (k / 8)) ? 8 : 0, 0, 0, 0, 0);
        cyc(1, 8, 1, 0, 0, 0);
        chk("simul_valid", int'(word_valid), 1);
        chk("simul_word", int'(word_out), 8'hAA);
        chk("simul_in_ready", int'(in_ready), 1);
        cyc(0, 0, 1, 0, 0, 0);

        // Reset with a word pending and three bits collected.
        for (int k = 0; k < 11; k++) cyc(1, 9, 0, 0, 0, 0);
        async_reset();
        for (int k = 0; k < N_CH; k++) cyc(1, 0, 1, 0, 0, 0);
        chk("post_rst_word", int'(word_out), 8'hFF);

`ifdef THRESH_FLIP_EN
        cyc(0, 0, 1, 1, 0, (1 << SUM_WIDTH) | 2);
        cyc(1, 1, 1, 0, 0, 0);
        for (int k = 1; k < N_CH; k++) cyc(1, 0, 1, 0, 0, 0);
        chk("flip_bit0_first", int'(word_out[0]), 1);
        cyc(1, 2, 1, 0, 0, 0);
        for (int k = 1; k < N_CH; k++) cyc(1, 0, 1, 0, 0, 0);
        chk("flip_bit0_second", int'(word_out[0]), 0);
`endif

        // Random traffic against the model.
        for (int n = 0; n < 2000; n++)
            cyc($urandom_range(0, 9) < 7, $urandom_range(0, (1 << SUM_WIDTH) - 1),
                $urandom_range(0, 9) < 6, $urandom_range(0, 9) == 0,
                $urandom_range(0, N_CH - 1), $urandom_range(0, (1 << TW) - 1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
